// File: rtl/lsu_misalign_seq.sv
// lsu_misalign_seq: splits word-crossing external loads/stores into aligned bus transactions and merges split load data
module lsu_misalign_seq #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_store,
  input  logic [31:0] req_wdata,
  input  logic        req_sideeffect,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        done_valid,
  output logic [31:0] done_data,
  output logic        done_err,
  output logic        done_split
);
  typedef enum logic [2:0] {IDLE, LO_REQ, LO_RSP, HI_REQ, HI_RSP, DONE} state_t;
  state_t      state_q, state_d;
  logic [29:0] word_q, word_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic        store_q, store_d, split_q, split_d;
  logic [31:0] wdata_q, wdata_d, lo_q, lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] done_data_q, done_data_d;
  logic        done_err_q, done_err_d, done_split_q, done_split_d;
  logic [2:0]  req_n;
  logic        req_aligned, req_split, timeout, hi;
  logic        fin, fin_err, fin_split;
  logic [31:0] fin_data;
  logic [3:0]  mask4;
  logic [7:0]  strb8;
  logic [63:0] wdata64;

  function automatic logic [31:0] merge(input logic [31:0] hi_w, input logic [31:0] lo_w,
                                        input logic [1:0] off, input logic [1:0] size);
    return 32'({hi_w, lo_w} >> {off, 3'b000}) &
           (size == 2'd0 ? 32'h0000_00FF : size == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF);
  endfunction

  assign req_n       = req_size == 2'd0 ? 3'd1 : req_size == 2'd1 ? 3'd2 : 3'd4;
  assign req_split   = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
  assign req_aligned = req_size == 2'd0 | (req_size == 2'd1 & ~req_addr[0]) | req_addr[1:0] == 2'd0;
  assign timeout     = cnt_q == 16'(RSP_TIMEOUT - 1);
  assign mask4       = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
  assign strb8       = {4'b0000, mask4} << off_q;
  assign wdata64     = {32'h0, wdata_q} << {off_q, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      off_q        <= '0;
      size_q       <= '0;
      store_q      <= 1'b0;
      split_q      <= 1'b0;
      wdata_q      <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      done_data_q  <= '0;
      done_err_q   <= 1'b0;
      done_split_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      off_q        <= off_d;
      size_q       <= size_d;
      store_q      <= store_d;
      split_q      <= split_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      done_data_q  <= done_data_d;
      done_err_q   <= done_err_d;
      done_split_q <= done_split_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    off_d        = off_q;
    size_d       = size_q;
    store_d      = store_q;
    split_d      = split_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q + 16'd1;
    done_data_d  = done_data_q;
    done_err_d   = done_err_q;
    done_split_d = done_split_q;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_split    = 1'b0;
    fin_data     = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        word_d  = req_addr[31:2];
        off_d   = req_addr[1:0];
        size_d  = req_size;
        store_d = req_store;
        split_d = req_split;
        wdata_d = req_wdata;
        fin     = req_sideeffect & ~req_aligned;
        fin_err = fin;
        state_d = LO_REQ;
      end
      LO_REQ, HI_REQ: begin
        cnt_d = '0;
        if (bus_ready) state_d = state_q == LO_REQ ? LO_RSP : HI_RSP;
      end
      LO_RSP: if (rsp_valid & ~rsp_err & split_q) begin
        lo_d    = rsp_data;
        state_d = HI_REQ;
      end else if (rsp_valid | timeout) begin
        fin      = 1'b1;
        fin_err  = ~rsp_valid | rsp_err;
        fin_data = merge(32'h0, rsp_data, off_q, size_q);
      end
      HI_RSP: if (rsp_valid | timeout) begin
        fin       = 1'b1;
        fin_err   = ~rsp_valid | rsp_err;
        fin_split = 1'b1;
        fin_data  = merge(rsp_data, lo_q, off_q, size_q);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a response arriving on the last timeout cycle is taken, so fin_err uses rsp_valid first
    if (fin) begin
      state_d      = DONE;
      done_err_d   = fin_err;
      done_split_d = fin_split;
      done_data_d  = (fin_err | store_d) ? '0 : fin_data;
    end
  end

  always_comb begin
    hi         = state_q == HI_REQ;
    bus_valid  = state_q == LO_REQ | hi;
    req_ready  = state_q == IDLE & ~rst;
    bus_addr   = bus_valid ? {word_q + 30'(hi), 2'b00} : '0;
    bus_write  = bus_valid & store_q;
    bus_wstrb  = ~bus_valid ? '0 : hi ? strb8[7:4] : strb8[3:0];
    bus_wdata  = ~bus_valid ? '0 : hi ? wdata64[63:32] : wdata64[31:0];
    done_valid = state_q == DONE;
    done_data  = done_data_q;
    done_err   = done_err_q;
    done_split = done_split_q;
  end
endmodule

// File: tb/tb_lsu_misalign_seq.sv
// tb_lsu_misalign_seq: randomized and directed checks of lsu_misalign_seq against a byte-level reference model
module tb_lsu_misalign_seq;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 0, req_store = 0, req_sideeffect = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic req_ready, bus_valid, bus_write, done_valid, done_err, done_split;
  logic bus_ready = 0, rsp_valid = 0, rsp_err = 0;
  logic [31:0] rsp_data = 0, bus_addr, bus_wdata, done_data;
  logic [3:0] bus_wstrb;

  always #5 clk = ~clk;

  lsu_misalign_seq #(.RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_store(req_store), .req_wdata(req_wdata), .req_sideeffect(req_sideeffect),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .done_valid(done_valid), .done_data(done_data), .done_err(done_err),
    .done_split(done_split));

  typedef struct packed {logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb;} cmd_t;
  cmd_t cmds[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] rd[2];
  logic re[2];
  logic [31:0] got_data;
  logic got_err, got_split, got_ready, got_prev_dv;
  bit got_done;
  int got_lat;
  logic [31:0] m_addr[2], m_wd[2], m_data;
  logic [3:0] m_strb[2];
  logic m_err, m_split;
  int m_n;

  // byte-by-byte view: each byte of the access lands in the low or high word by its own address
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic st,
                                input logic [31:0] wd, input logic se);
    int n, w, lane;
    logic [31:0] b;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    m_addr[0] = {a[31:2], 2'b00};
    m_addr[1] = m_addr[0] + 32'd4;
    m_strb[0] = 0; m_strb[1] = 0; m_wd[0] = 0; m_wd[1] = 0;
    m_data = 0; m_err = 0; m_split = 0;
    if (se && (a % n) != 0) begin m_n = 0; m_err = 1; return; end
    m_n = (a % 4) + n > 4 ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      b = a + i;
      w = b[31:2] == a[31:2] ? 0 : 1;
      lane = int'(b[1:0]);
      m_strb[w][lane] = 1'b1;
      m_wd[w][8*lane +: 8] = wd[8*i +: 8];
      m_data[8*i +: 8] = w == 1 ? rd[1][8*lane +: 8] : rd[0][8*lane +: 8];
    end
    if (re[0]) begin m_n = 1; m_err = 1; end
    else if (m_n == 2 && re[1]) m_err = 1;
    m_split = m_n == 2;
    if (m_err || st) m_data = 0;
  endfunction

  // drives one request and acts as the bus; records what the DUT did
  task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic st, input logic [31:0] wd,
                        input logic se, input int bwait, input int rwait, input logic [1:0] respond);
    int wc = 0, due = -1, di = 0, idx;
    cmd_t x;
    cmds.delete(); got_done = 0; got_lat = -1;
    @(negedge clk);
    got_ready = req_ready; got_prev_dv = done_valid;
    req_valid = 1; req_addr = a; req_size = sz; req_store = st; req_wdata = wd; req_sideeffect = se;
    for (int c = 1; c < 60 && !got_done; c++) begin
      @(negedge clk);
      req_valid = 0; bus_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_data = 0;
      if (done_valid) begin
        got_done = 1; got_lat = c; got_data = done_data; got_err = done_err; got_split = done_split;
      end else begin
        if (due == c) begin rsp_valid = 1; rsp_data = rd[di]; rsp_err = re[di]; end
        if (bus_valid) begin
          if (wc >= bwait) begin
            bus_ready = 1;
            x.addr = bus_addr; x.write = bus_write; x.wdata = bus_wdata; x.wstrb = bus_wstrb;
            cmds.push_back(x);
            idx = (cmds.size() - 1) % 2;
            if (respond[idx]) begin due = c + 1 + rwait; di = idx; end
            wc = 0;
          end else wc++;
        end
      end
    end
  endtask

  task automatic test_reset;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_in_reset got=%b want=0", req_ready); end
    n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bus_valid got=%b want=0", bus_valid); end
    rst = 0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got=%b want=1", req_ready); end
    n_chk++; if ({done_valid, done_err, done_split, done_data} !== 35'h0) begin n_fail++; $display("FAIL rst_done got=%b%b%b %h want=0", done_valid, done_err, done_split, done_data); end
    n_chk++; if ({bus_addr, bus_wstrb, bus_write, bus_wdata} !== 69'h0) begin n_fail++; $display("FAIL rst_bus got=%h %b want=0", bus_addr, bus_wstrb); end
  endtask

  task automatic test_store_split;
    rd[0] = 0; rd[1] = 0; re[0] = 0; re[1] = 0;
    access(32'h2000_0001, 2'd2, 1, 32'hAABB_CCDD, 0, 0, 0, 2'b11);
    n_chk++; if (cmds.size() != 2) begin n_fail++; $display("FAIL sw_ncmd got=%0d want=2", cmds.size()); end
    else begin
      n_chk++; if (cmds[0] !== {32'h2000_0000, 1'b1, 32'hBBCC_DD00, 4'b1110}) begin n_fail++; $display("FAIL sw_lo got=%h want=%h", cmds[0], {32'h2000_0000, 1'b1, 32'hBBCC_DD00, 4'b1110}); end
      n_chk++; if (cmds[1] !== {32'h2000_0004, 1'b1, 32'h0000_00AA, 4'b0001}) begin n_fail++; $display("FAIL sw_hi got=%h want=%h", cmds[1], {32'h2000_0004, 1'b1, 32'h0000_00AA, 4'b0001}); end
    end
    n_chk++; if (!got_done || got_split !== 1'b1 || got_err !== 1'b0 || got_data !== 0) begin n_fail++; $display("FAIL sw_done got=%0d split=%b err=%b data=%h want 1 1 0 0", got_done, got_split, got_err, got_data); end
  endtask

  task automatic test_load_split_half;
    rd[0] = 32'h1122_3344; rd[1] = 32'h5566_7788; re[0] = 0; re[1] = 0;
    access(32'h3000_0003, 2'd1, 0, 0, 0, 0, 0, 2'b11);
    n_chk++; if (cmds.size() != 2 || cmds[0].addr !== 32'h3000_0000 || cmds[1].addr !== 32'h3000_0004) begin n_fail++; $display("FAIL lh_addrs got n=%0d want 2 cmds at 30000000/30000004", cmds.size()); end
    n_chk++; if (got_data !== 32'h0000_8811) begin n_fail++; $display("FAIL lh_data got=%h want=00008811", got_data); end
    n_chk++; if (got_lat != 5 || got_split !== 1'b1) begin n_fail++; $display("FAIL lh_lat got=%0d split=%b want=5 1", got_lat, got_split); end
  endtask

  task automatic test_load_byte;
    rd[0] = 32'hDEAD_BEEF; re[0] = 0; re[1] = 0;
    access(32'h4000_0002, 2'd0, 0, 0, 0, 0, 0, 2'b11);
    n_chk++; if (cmds.size() != 1 || cmds[0].wstrb !== 4'b0100) begin n_fail++; $display("FAIL lb_cmd got n=%0d want 1 cmd wstrb 0100", cmds.size()); end
    n_chk++; if (got_data !== 32'h0000_00AD || got_lat != 3 || got_split !== 1'b0) begin n_fail++; $display("FAIL lb_done got=%h lat=%0d split=%b want=000000ad 3 0", got_data, got_lat, got_split); end
  endtask

  task automatic test_sideeffect;
    access(32'h5000_0002, 2'd2, 0, 0, 1, 0, 0, 2'b11);
    n_chk++; if (cmds.size() != 0) begin n_fail++; $display("FAIL se_nocmd got=%0d want=0", cmds.size()); end
    n_chk++; if (got_lat != 1 || got_err !== 1'b1 || got_data !== 0) begin n_fail++; $display("FAIL se_done got lat=%0d err=%b data=%h want 1 1 0", got_lat, got_err, got_data); end
  endtask

  task automatic test_lo_err;
    rd[0] = 32'hFFFF_FFFF; re[0] = 1; re[1] = 0;
    access(32'h7000_0002, 2'd2, 0, 0, 0, 0, 0, 2'b11);
    n_chk++; if (cmds.size() != 1) begin n_fail++; $display("FAIL loerr_ncmd got=%0d want=1", cmds.size()); end
    n_chk++; if (got_err !== 1'b1 || got_data !== 0 || got_lat != 3) begin n_fail++; $display("FAIL loerr_done got err=%b data=%h lat=%0d want 1 0 3", got_err, got_data, got_lat); end
    re[0] = 0;
  endtask

  task automatic test_wrap;
    re[0] = 0; re[1] = 0;
    access(32'hFFFF_FFFE, 2'd2, 1, 32'h1234_5678, 0, 1, 0, 2'b11);
    n_chk++; if (cmds.size() != 2 || cmds[1].addr !== 32'h0 || cmds[1].wstrb !== 4'b0011 || cmds[1].wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL wrap_hi got n=%0d want hi cmd at 0 wstrb 0011 wdata 00001234", cmds.size()); end
  endtask

  task automatic test_timeout;
    rd[0] = 32'h89AB_CDEF; re[0] = 0; re[1] = 0;
    access(32'h6000_0000, 2'd2, 0, 0, 0, 0, 0, 2'b00);
    n_chk++; if (!got_done || got_lat != 2 + TO || got_err !== 1'b1 || got_data !== 0) begin n_fail++; $display("FAIL to_lo got done=%0d lat=%0d err=%b want 1 %0d 1", got_done, got_lat, got_err, 2 + TO); end
    @(negedge clk); rsp_valid = 1; rsp_data = 32'hCAFE_F00D;
    @(negedge clk); rsp_valid = 0;
    n_chk++; if (done_valid !== 1'b0 || done_err !== 1'b1 || req_ready !== 1'b1 || bus_valid !== 1'b0) begin n_fail++; $display("FAIL to_late got dv=%b err=%b rdy=%b bv=%b want 0 1 1 0", done_valid, done_err, req_ready, bus_valid); end
    access(32'h6000_0006, 2'd2, 0, 0, 0, 0, 0, 2'b01);
    n_chk++; if (got_lat != 4 + TO || got_err !== 1'b1 || got_split !== 1'b1 || cmds.size() != 2) begin n_fail++; $display("FAIL to_hi got lat=%0d err=%b split=%b n=%0d want %0d 1 1 2", got_lat, got_err, got_split, cmds.size(), 4 + TO); end
    access(32'h6000_0004, 2'd2, 0, 0, 0, 0, TO - 1, 2'b01);
    n_chk++; if (got_lat != 2 + TO || got_err !== 1'b0 || got_data !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL to_edge got lat=%0d err=%b data=%h want %0d 0 89abcdef", got_lat, got_err, got_data, 2 + TO); end
  endtask

  task automatic test_back_to_back;
    rd[0] = 32'h0BAD_F00D; re[0] = 0; re[1] = 0;
    access(32'h0000_0100, 2'd2, 0, 0, 0, 0, 0, 2'b11);
    access(32'h0000_0104, 2'd1, 0, 0, 0, 0, 0, 2'b11);
    n_chk++; if (got_ready !== 1'b1 || got_prev_dv !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got rdy=%b dv=%b want 1 0", got_ready, got_prev_dv); end
    n_chk++; if (got_data !== 32'h0000_F00D || got_lat != 3) begin n_fail++; $display("FAIL b2b_data got=%h lat=%0d want 0000f00d 3", got_data, got_lat); end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, bm;
    logic [1:0] sz;
    logic st, se;
    int bw, rw;
    for (int it = 0; it < 40; it++) begin
      a = $urandom; wd = $urandom; sz = 2'($urandom_range(0, 3)); st = 1'($urandom_range(0, 1));
      se = $urandom_range(0, 3) == 0; bw = $urandom_range(0, 2); rw = $urandom_range(0, TO - 1);
      rd[0] = $urandom; rd[1] = $urandom; re[0] = $urandom_range(0, 7) == 0; re[1] = $urandom_range(0, 7) == 0;
      model(a, sz, st, wd, se);
      access(a, sz, st, wd, se, bw, rw, 2'b11);
      n_chk++; if (got_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready got=%b want=1", it, got_ready); end
      n_chk++; if (!got_done || got_lat != 1 + m_n * (2 + bw + rw)) begin n_fail++; $display("FAIL rnd%0d_lat got=%0d want=%0d", it, got_lat, 1 + m_n * (2 + bw + rw)); end
      n_chk++; if ({got_err, got_split, got_data} !== {m_err, m_split, m_data}) begin n_fail++; $display("FAIL rnd%0d_done got err=%b split=%b data=%h want %b %b %h", it, got_err, got_split, got_data, m_err, m_split, m_data); end
      n_chk++; if (cmds.size() != m_n) begin n_fail++; $display("FAIL rnd%0d_ncmd got=%0d want=%0d", it, cmds.size(), m_n); end
      for (int k = 0; k < cmds.size() && k < m_n; k++) begin
        for (int l = 0; l < 4; l++) bm[8*l +: 8] = {8{m_strb[k][l]}};
        n_chk++; if ({cmds[k].addr, cmds[k].write, cmds[k].wstrb, cmds[k].wdata & bm} !== {m_addr[k], st, m_strb[k], m_wd[k]}) begin
          n_fail++; $display("FAIL rnd%0d_cmd%0d got a=%h w=%b s=%b d=%h want a=%h w=%b s=%b d=%h", it, k, cmds[k].addr, cmds[k].write, cmds[k].wstrb, cmds[k].wdata & bm, m_addr[k], st, m_strb[k], m_wd[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h0000_0010; req_size = 2'd2; req_store = 0; req_sideeffect = 0;
    @(negedge clk);
    req_valid = 0; bus_ready = 0;
    n_chk++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL rm_bus_up got=%b want=1", bus_valid); end
    rst = 1;
    @(negedge clk);
    n_chk++; if (bus_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_reset got bv=%b rdy=%b want 0 0", bus_valid, req_ready); end
    rst = 0;
    @(negedge clk);
    rsp_valid = 1; rsp_data = 32'h5555_AAAA;
    n_chk++; if (req_ready !== 1'b1 || done_err !== 1'b0) begin n_fail++; $display("FAIL rm_after got rdy=%b err=%b want 1 0", req_ready, done_err); end
    @(negedge clk);
    rsp_valid = 0;
    n_chk++; if (done_valid !== 1'b0 || bus_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale_rsp got dv=%b bv=%b want 0 0", done_valid, bus_valid); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    test_store_split;
    test_load_split_half;
    test_load_byte;
    test_sideeffect;
    test_lo_err;
    test_wrap;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_misalign_seq.md
# lsu_misalign_seq

Sequencer between the LSU address-check stage and the external bus interface. It accepts one external (non-DCCM, non-PIC) load or store per request and issues one or two word-aligned bus transactions. An access that crosses a 32-bit word boundary is split into a low-word and a high-word transaction. For split loads the block merges the two response words into one result. Side-effect accesses that are misaligned are never split: they complete with an error and issue no bus traffic.

## Interface
Parameters:
- RSP_TIMEOUT, default 255: maximum number of cycles to wait for a bus response before the access ends with an error. Legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  byte address
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word (3 is illegal; the block treats it as word)
- req_store  in  1  1 = store, 0 = load
- req_wdata  in  32  store data, right-justified
- req_sideeffect  in  1  side-effect region flag from the address check
- bus_valid  out  1  bus command valid
- bus_ready  in  1  bus command accepted when bus_valid & bus_ready
- bus_addr  out  32  word-aligned address; bits [1:0] are always 0
- bus_write  out  1  store command
- bus_wdata  out  32  lane-aligned store data
- bus_wstrb  out  4  byte enables
- rsp_valid  in  1  bus response valid (one response per command)
- rsp_data  in  32  load data, full word
- rsp_err  in  1  bus error
- done_valid  out  1  one-cycle completion pulse
- done_data  out  32  load result, right-justified and zero-extended above the access size; 0 for stores
- done_err  out  1  the access failed
- done_split  out  1  the access used two bus transactions

## Operation
- Decode on accept, all values captured in registers:
  - off = req_addr[1:0]
  - n = 1 << size (number of bytes)
  - mask = (1 << n) - 1
  - split = (off + n > 4)
- Low transaction:
  - bus_addr = {addr[31:2], 2'b00}
  - bus_wstrb = (mask << off)[3:0]
  - bus_wdata = (wdata << 8*off)[31:0]
- High transaction:
  - bus_addr = low address + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000)
  - bus_wstrb = mask >> (4 - off)
  - bus_wdata = wdata >> 8*(4 - off)
- Load merge: ({hi_data, lo_data} >> 8*off)[31:0], then bytes at and above n are zeroed. A non-split load uses lo_data alone with the same shift and zeroing.
- Misaligned side-effect request: req_sideeffect & ~aligned, where aligned means word with off == 0, half with off[0] == 0, or any byte. The block goes directly to DONE with done_err = 1 and issues no bus command.
- State machine:
  - IDLE: req_ready = 1. On accept, go to DONE if the request is a misaligned side-effect access, otherwise to LO_REQ.
  - LO_REQ: hold bus_valid = 1 and a stable command until bus_ready, then go to LO_RSP.
  - LO_RSP: wait for rsp_valid.
    - rsp_err → DONE with error; the high transaction is skipped.
    - Otherwise → HI_REQ if split, else DONE.
  - HI_REQ, HI_RSP: same as LO_REQ and LO_RSP for the high word. HI_RSP always goes to DONE.
  - DONE: done_valid = 1 for one cycle, then IDLE.
- Timeout: a counter clears on entry to LO_RSP or HI_RSP and increments every cycle without rsp_valid. When it reaches RSP_TIMEOUT, go to DONE with done_err = 1.
- rsp_valid is ignored in every state other than LO_RSP and HI_RSP. This includes late responses after a timeout.
- done_err, done_data and done_split stay stable from DONE until the next DONE. done_data is 0 on any error.

## Timing
- Reset values: req_ready = 0 in the reset cycle and 1 in the first cycle after reset. All other outputs are 0. The state is IDLE.
- Reset mid-operation: the block returns to IDLE on the next edge. bus_valid drops even if the command was not accepted. Pending responses are discarded.
- Only one bus command is ever outstanding.
- The bus command is registered: bus_valid rises the cycle after the accept.
- rsp_valid is sampled no earlier than the cycle after the command handshake.
- Minimum latency, with bus_ready = 1 and the response arriving one cycle after the handshake (accept at cycle 0):
  - non-split: bus_valid at cycle 1, response at cycle 2, done_valid at cycle 3
  - split: done_valid at cycle 5
  - misaligned side-effect: done_valid at cycle 1
- A new request is accepted only in IDLE. Minimum non-split throughput is one request per 4 cycles.
- An rsp_valid coincident with the timeout reaching RSP_TIMEOUT wins: the response is taken and there is no error.

## Test plan
- Store word, addr 0x2000_0001, wdata 0xAABBCCDD → two transactions:
  - 0x2000_0000, wstrb 1110, wdata 0xBBCCDD00
  - 0x2000_0004, wstrb 0001, wdata 0x000000AA
  - then done_split = 1, done_err = 0.
- Load half, addr 0x3000_0003, lo rsp 0x11223344, hi rsp 0x55667788 → bus addresses 0x3000_0000 and 0x3000_0004; done_data = 0x00008811, done_split = 1, done at cycle 5 with zero-wait bus.
- Load byte, addr 0x4000_0002, rsp 0xDEADBEEF → one transaction, wstrb 0100, done_data = 0x000000AD, done at cycle 3.
- Load word, addr 0x5000_0002, req_sideeffect = 1 → no bus_valid; done_valid at cycle 1 with done_err = 1.
- Split load with rsp_err = 1 on the low response → no high command; done_err = 1, done_data = 0.
- RSP_TIMEOUT = 4 with no response → done_err at the 4th wait cycle; a late rsp_valid is ignored. Assert rst while bus_valid = 1 and bus_ready = 0 → bus_valid = 0 the next cycle, and req_ready = 1 the cycle after reset deasserts.
